// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock/run/step controller.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HALT     = 2'b00;
  localparam logic [1:0] MODE_RUN_DIV  = 2'b01;
  localparam logic [1:0] MODE_RUN_FULL = 2'b10;

  // Reserved encoding 2'b11 deliberately falls through to "not running".
  function automatic logic is_run_mode(input logic [1:0] m);
    return (m == MODE_RUN_DIV) || (m == MODE_RUN_FULL);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_step_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// rising-edge detector producing a single-cycle step pulse.
module step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_stab_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_level    <= 1'b0;
      r_level_q  <= 1'b0;
      r_stab_cnt <= '0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt == CNT_LAST) begin
        r_level    <= r_sync2;
        r_stab_cnt <= '0;
      end else begin
        r_stab_cnt <= r_stab_cnt + CNT_ONE;
      end
    end
  end

  assign btn_pulse = r_level & ~r_level_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller for the core's slow clock domain: programmable
// divider, debounced single-step and a registered one-cycle core enable.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 step_btn,
  input  logic                 halt_req,
  output logic                 cpu_en,
  output logic                 clk_slow,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] en_count
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET =
    (DEFAULT_DIV == 0) ? DIV_ONE : DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_clk_slow;
  logic                 r_cpu_en;
  logic                 r_running;
  logic [CNT_WIDTH-1:0] r_en_count;
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_tick;
  logic                 w_step_pulse;
  logic                 w_run_ok;
  logic                 w_en_next;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (step_btn),
    .btn_pulse(w_step_pulse)
  );

  // A load restarts the count, so the load cycle itself never ticks.
  assign w_tick   = !div_load && (r_div_cnt == (r_div - DIV_ONE));
  assign w_run_ok = is_run_mode(mode) && !halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= DIV_RESET;
      r_div_cnt  <= '0;
      r_clk_slow <= 1'b0;
    end else begin
      if (div_load) begin
        r_div     <= (div_value == '0) ? DIV_ONE : div_value;
        r_div_cnt <= '0;
      end else if (w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_ONE;
      end
      if (w_tick) begin
        r_clk_slow <= ~r_clk_slow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HALTED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HALTED: begin
        if (w_run_ok) begin
          w_state_next = RUN;
        end else if (w_step_pulse) begin
          w_state_next = STEP;
        end
      end
      RUN: begin
        if (!w_run_ok) begin
          w_state_next = HALTED;
        end
      end
      STEP: begin
        if (w_tick) begin
          w_state_next = HALTED;
        end
      end
      default: w_state_next = HALTED;
    endcase
  end

  // A pending step ignores mode and halt_req; RUN honours halt over tick.
  always_comb begin
    w_en_next = 1'b0;
    case (r_state)
      RUN: begin
        if (w_run_ok) begin
          w_en_next = (mode == MODE_RUN_FULL) ? 1'b1 : w_tick;
        end
      end
      STEP:    w_en_next = w_tick;
      default: w_en_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_en   <= 1'b0;
      r_running  <= 1'b0;
      r_en_count <= '0;
    end else begin
      r_cpu_en  <= w_en_next;
      r_running <= (w_state_next == RUN);
      if (w_en_next && (r_en_count != '1)) begin
        r_en_count <= r_en_count + CNT_ONE;
      end
    end
  end

  assign cpu_en   = r_cpu_en;
  assign clk_slow = r_clk_slow;
  assign running  = r_running;
  assign en_count = r_en_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl with a divisor of 4, a
// 3-cycle debounce and an 8-bit enable counter so saturation is reachable.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = MODE_HALT;
  logic        div_load = 1'b0;
  logic [31:0] div_value = '0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_en;
  logic        clk_slow;
  logic        running;
  logic [7:0]  en_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV_WIDTH(32),
    .DEFAULT_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .CNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .div_load (div_load),
    .div_value(div_value),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .cpu_en   (cpu_en),
    .clk_slow (clk_slow),
    .running  (running),
    .en_count (en_count)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    checks++;
    if ({cpu_en, clk_slow, running} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got en/slow/run=%b expected 000", {cpu_en, clk_slow, running});
    end
    checks++;
    if (en_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", en_count);
    end
  endtask

  // Release reset in mode 01: first enable 4 cycles later, then every 4.
  task automatic test_run_div();
    int pulses = 0;
    int first = -1;
    int last = -1;
    int bad_gap = 0;
    int bad_sync = 0;
    logic slow_prev;
    mode = MODE_RUN_DIV;
    rst_n = 1'b1;
    slow_prev = clk_slow;
    for (int c = 1; c <= 40 && pulses < 5; c++) begin
      cyc();
      if (c == 1) begin
        checks++;
        if (running !== 1'b1) begin
          errors++;
          $display("FAIL run_div_running: got %b expected 1", running);
        end
      end
      if ((clk_slow !== slow_prev) !== (cpu_en === 1'b1)) bad_sync++;
      slow_prev = clk_slow;
      if (cpu_en === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
        else if (c - last != 4) bad_gap++;
        last = c;
      end
    end
    exp_count = 5;
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL run_div_pulses: got %0d expected 5 within 40 cycles", pulses);
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL run_div_first: got cycle %0d expected 4", first);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL run_div_period: got %0d bad gaps expected 0", bad_gap);
    end
    checks++;
    if (bad_sync != 0) begin
      errors++;
      $display("FAIL run_div_clk_slow: got %0d cycles out of step expected 0", bad_sync);
    end
    checks++;
    if (clk_slow !== 1'b1) begin
      errors++;
      $display("FAIL run_div_slow_level: got %b expected 1", clk_slow);
    end
    checks++;
    if (en_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL run_div_count: got %0d expected %0d", en_count, exp_count);
    end
  endtask

  task automatic test_run_full();
    int low = 0;
    mode = MODE_RUN_FULL;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (cpu_en !== 1'b1 || running !== 1'b1) low++;
    end
    exp_count += 10;
    checks++;
    if (low != 0) begin
      errors++;
      $display("FAIL run_full_high: got %0d idle cycles expected 0", low);
    end
    mode = MODE_HALT;
    cyc();
    checks++;
    if ({cpu_en, running} !== 2'b00) begin
      errors++;
      $display("FAIL run_full_stop: got en/run=%b expected 00", {cpu_en, running});
    end
    checks++;
    if (en_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL run_full_count: got %0d expected %0d", en_count, exp_count);
    end
  endtask

  // 2-cycle glitch is rejected; a 5-cycle press steps exactly once even with
  // halt_req held, and the enable lands on a divider tick.
  task automatic test_step();
    int pulses = 0;
    int off_tick = 0;
    int ran = 0;
    logic slow_prev;
    cyc(2);
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL step_glitch: got %0d enables expected 0", pulses);
    end
    halt_req = 1'b1;
    step_btn = 1'b1;
    slow_prev = clk_slow;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (c == 4) step_btn = 1'b0;
      if (running !== 1'b0) ran++;
      if (cpu_en === 1'b1) begin
        pulses++;
        if (clk_slow === slow_prev) off_tick++;
      end
      slow_prev = clk_slow;
    end
    halt_req = 1'b0;
    exp_count += 1;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL step_once: got %0d enables expected 1", pulses);
    end
    checks++;
    if (off_tick != 0 || ran != 0) begin
      errors++;
      $display("FAIL step_timing: got %0d off-tick, %0d running cycles expected 0 and 0", off_tick, ran);
    end
    checks++;
    if (en_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL step_count: got %0d expected %0d", en_count, exp_count);
    end
  endtask

  // Resync divider with a load, then raise halt_req in the cycle the tick is due.
  task automatic test_halt_req();
    logic slow_prev;
    mode = MODE_RUN_DIV;
    div_load = 1'b1;
    div_value = 32'd4;
    cyc();
    div_load = 1'b0;
    cyc(3);
    checks++;
    if ({running, cpu_en} !== 2'b10) begin
      errors++;
      $display("FAIL halt_pre: got run/en=%b expected 10", {running, cpu_en});
    end
    slow_prev = clk_slow;
    halt_req = 1'b1;
    cyc();
    checks++;
    if ({running, cpu_en} !== 2'b00) begin
      errors++;
      $display("FAIL halt_wins: got run/en=%b expected 00", {running, cpu_en});
    end
    checks++;
    if (clk_slow === slow_prev) begin
      errors++;
      $display("FAIL halt_divider: got clk_slow=%b expected toggle from %b", clk_slow, slow_prev);
    end
    checks++;
    if (en_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL halt_count: got %0d expected %0d", en_count, exp_count);
    end
  endtask

  task automatic test_div_load();
    int low = 0;
    int bad = 0;
    logic slow_prev;
    halt_req = 1'b0;
    mode = MODE_RUN_DIV;
    div_load = 1'b1;
    div_value = 32'd0;
    cyc();
    div_load = 1'b0;
    checks++;
    if ({running, cpu_en} !== 2'b10) begin
      errors++;
      $display("FAIL div0_load_cycle: got run/en=%b expected 10", {running, cpu_en});
    end
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (cpu_en !== 1'b1) low++;
    end
    exp_count += 6;
    checks++;
    if (low != 0) begin
      errors++;
      $display("FAIL div0_every_cycle: got %0d idle cycles expected 0", low);
    end
    slow_prev = clk_slow;
    div_load = 1'b1;
    div_value = 32'd7;
    cyc();
    div_load = 1'b0;
    checks++;
    if (cpu_en !== 1'b0 || clk_slow !== slow_prev) begin
      errors++;
      $display("FAIL div7_load_cycle: got en=%b slow=%b expected en=0 slow=%b", cpu_en, clk_slow, slow_prev);
    end
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (cpu_en !== ((c == 7) || (c == 14))) bad++;
    end
    exp_count += 2;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL div7_period: got %0d wrong cycles expected 0", bad);
    end
    checks++;
    if (en_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL div_load_count: got %0d expected %0d", en_count, exp_count);
    end
  endtask

  task automatic test_saturate();
    mode = MODE_RUN_FULL;
    cyc(300);
    exp_count = 255;
    checks++;
    if (en_count !== 8'(exp_count) || cpu_en !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got count=%0d en=%b expected 255 and 1", en_count, cpu_en);
    end
    mode = MODE_HALT;
    cyc();
  endtask

  // Reset lands while a step waits on a long divisor, then while running flat out.
  task automatic test_reset_mid();
    int pulses = 0;
    int first = -1;
    div_load = 1'b1;
    div_value = 32'd100;
    cyc();
    div_load = 1'b0;
    step_btn = 1'b1;
    cyc(5);
    step_btn = 1'b0;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_en, clk_slow, running} !== 3'b000 || en_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_step: got en/slow/run=%b count=%0d expected 000 and 0", {cpu_en, clk_slow, running}, en_count);
    end
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || en_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_step_dropped: got %0d enables count=%0d expected 0 and 0", pulses, en_count);
    end
    mode = MODE_RUN_FULL;
    cyc(3);
    checks++;
    if ({running, cpu_en} !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre_run: got run/en=%b expected 11", {running, cpu_en});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_en, clk_slow, running} !== 3'b000 || en_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_run: got en/slow/run=%b count=%0d expected 000 and 0", {cpu_en, clk_slow, running}, en_count);
    end
    cyc();
    mode = MODE_RUN_DIV;
    rst_n = 1'b1;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      cyc();
      if (cpu_en === 1'b1) first = c;
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL reset_div_default: got first enable at cycle %0d expected 4", first);
    end
    checks++;
    if (en_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_count_restart: got %0d expected 1", en_count);
    end
  endtask

  initial begin
    test_reset();
    test_run_div();
    test_run_full();
    test_step();
    test_halt_req();
    test_div_load();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
